// File: rtl/seg7_hex_sched.sv
// Hex-to-7-segment write scheduler: turns one 32-bit hex request into two
// display-register word writes and shares the write port with a CPU that has priority.
module seg7_hex_sched #(
  parameter int unsigned MAX_STALL = 8,
  parameter bit          INVERT    = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_we,
  input  logic        cpu_A,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_D,
  output logic        cpu_stall,
  input  logic        hex_valid,
  input  logic [31:0] hex_value,
  input  logic [7:0]  hex_dp,
  output logic        hex_ready,
  output logic        hex_done,
  output logic        seg_we,
  output logic        seg_A,
  output logic [3:0]  seg_be,
  output logic [31:0] seg_D
);

  typedef enum logic [1:0] {IDLE, WR0, WR1} state_t;

  localparam logic [7:0] MAX_STALL_C = MAX_STALL[7:0];

  state_t      state_q, state_d;
  logic [7:0]  stall_cnt_q, stall_cnt_d;
  logic [31:0] val_q, val_d;
  logic [7:0]  dp_q, dp_d;
  logic        done_q, done_d;
  logic [31:0] word0, word1;
  logic        fsm_win;

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] seg_byte(input logic [3:0] nib, input logic dp);
    logic [7:0] b;
    b = {dp, hex_seg(nib)};
    return INVERT ? ~b : b;
  endfunction

  // Digit 0 is the most significant nibble and lands in byte 0 of word 0.
  always_comb begin
    word0 = '0;
    word1 = '0;
    for (int i = 0; i < 4; i++) begin
      word0[8*i +: 8] = seg_byte(val_q[31-4*i -: 4], dp_q[i]);
      word1[8*i +: 8] = seg_byte(val_q[15-4*i -: 4], dp_q[i+4]);
    end
  end

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    val_d       = val_q;
    dp_d        = dp_q;
    done_d      = 1'b0;
    fsm_win     = 1'b0;
    hex_ready   = 1'b0;
    cpu_stall   = 1'b0;
    seg_we      = cpu_we;
    seg_A       = cpu_A;
    seg_be      = cpu_be;
    seg_D       = cpu_D;
    case (state_q)
      IDLE: begin
        hex_ready   = 1'b1;
        stall_cnt_d = '0;
        if (hex_valid) begin
          val_d   = hex_value;
          dp_d    = hex_dp;
          state_d = WR0;
        end
      end
      WR0, WR1: begin
        // The CPU keeps the port until it has preempted us MAX_STALL times in a row.
        fsm_win = !cpu_we || (stall_cnt_q >= MAX_STALL_C);
        if (fsm_win) begin
          seg_we      = 1'b1;
          seg_A       = (state_q == WR1);
          seg_be      = 4'hF;
          seg_D       = (state_q == WR1) ? word1 : word0;
          cpu_stall   = cpu_we;
          stall_cnt_d = '0;
          done_d      = (state_q == WR1);
          state_d     = (state_q == WR1) ? IDLE : WR1;
        end else if (stall_cnt_q != 8'hFF) begin
          stall_cnt_d = stall_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst_n) begin
      seg_we    = 1'b0;
      cpu_stall = 1'b0;
      hex_ready = 1'b0;
    end
  end

  assign hex_done = done_q & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stall_cnt_q <= '0;
      val_q       <= '0;
      dp_q        <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      val_q       <= val_d;
      dp_q        <= dp_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_seg7_hex_sched.sv
// Bench for seg7_hex_sched: three instances (default, INVERT=1, MAX_STALL=2) share
// stimulus; a queue-of-words reference model plus directed vectors check them.
module tb_seg7_hex_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cpu_we, cpu_A, hex_valid;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_D, hex_value;
  logic [7:0]  hex_dp;

  logic [2:0]  cpu_stall, hex_ready, hex_done, seg_we, seg_A;
  logic [3:0]  seg_be [3];
  logic [31:0] seg_D [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    seg7_hex_sched #(.MAX_STALL((g == 2) ? 2 : 8), .INVERT(g == 1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_we(cpu_we), .cpu_A(cpu_A), .cpu_be(cpu_be), .cpu_D(cpu_D),
      .cpu_stall(cpu_stall[g]),
      .hex_valid(hex_valid), .hex_value(hex_value), .hex_dp(hex_dp),
      .hex_ready(hex_ready[g]), .hex_done(hex_done[g]),
      .seg_we(seg_we[g]), .seg_A(seg_A[g]), .seg_be(seg_be[g]), .seg_D(seg_D[g])
    );
  end

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0]  CODES [16];
  int          pn [3];
  logic [31:0] pw [3][2];
  int          starve [3];
  bit          done_m [3];

  typedef struct {
    logic [31:0] val;
    logic [7:0]  dp;
    int          k;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] enc(input logic [31:0] v, input logic [7:0] dp, input bit inv);
    logic [63:0] r;
    logic [7:0]  b;
    logic [3:0]  n;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      n = v[31-4*i -: 4];
      b = CODES[n];
      b[7] = dp[i];
      if (inv) b = ~b;
      r[8*i +: 8] = b;
    end
    return r;
  endfunction

  // Each instance: pending words, CPU-preemption count, and a done flag.
  task automatic model_tick();
    for (int k = 0; k < 3; k++) begin
      int          ms, pn0;
      bit          inv, win, e_we, e_A, e_stall;
      logic [3:0]  e_be;
      logic [31:0] e_D;
      logic [63:0] w;
      ms  = (k == 2) ? 2 : 8;
      inv = (k == 1);
      pn0 = pn[k];
      if (!rst_n) begin
        chk($sformatf("d%0d_rst_we", k), 32'(seg_we[k]), 32'd0);
        chk($sformatf("d%0d_rst_stall", k), 32'(cpu_stall[k]), 32'd0);
        chk($sformatf("d%0d_rst_ready", k), 32'(hex_ready[k]), 32'd0);
        chk($sformatf("d%0d_rst_done", k), 32'(hex_done[k]), 32'd0);
        pn[k] = 0;
        starve[k] = 0;
        done_m[k] = 1'b0;
      end else begin
        win = (pn0 > 0) && (!cpu_we || starve[k] >= ms);
        if (win) begin
          e_we = 1'b1; e_A = (pn0 == 1); e_be = 4'hF; e_D = pw[k][2-pn0]; e_stall = cpu_we;
        end else begin
          e_we = cpu_we; e_A = cpu_A; e_be = cpu_be; e_D = cpu_D; e_stall = 1'b0;
        end
        chk($sformatf("d%0d_we", k), 32'(seg_we[k]), 32'(e_we));
        chk($sformatf("d%0d_stall", k), 32'(cpu_stall[k]), 32'(e_stall));
        chk($sformatf("d%0d_ready", k), 32'(hex_ready[k]), 32'(pn0 == 0));
        chk($sformatf("d%0d_done", k), 32'(hex_done[k]), 32'(done_m[k]));
        if (e_we) begin
          chk($sformatf("d%0d_addr_be", k), {27'd0, seg_A[k], seg_be[k]}, {27'd0, e_A, e_be});
          chk($sformatf("d%0d_data", k), seg_D[k], e_D);
        end
        done_m[k] = win && (pn0 == 1);
        if (win) begin
          pn[k] = pn0 - 1;
          starve[k] = 0;
        end else if (pn0 > 0 && cpu_we && starve[k] < 255) begin
          starve[k]++;
        end
        if (pn0 == 0 && hex_valid) begin
          w = enc(hex_value, hex_dp, inv);
          pw[k][0] = w[31:0];
          pw[k][1] = w[63:32];
          pn[k] = 2;
        end
      end
    end
  endtask

  task automatic tick();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tick();
    end
  endtask

  initial begin
    CODES = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    vecs[0] = '{32'h0123ABCD, 8'h00, 0, 32'h4F5B063F, 32'h5E397C77};
    vecs[1] = '{32'h88888888, 8'h01, 1, 32'h80808000, 32'h80808080};
    vecs[2] = '{32'h456789EF, 8'hFF, 0, 32'h87FDEDE6, 32'hF1F9EFFF};
    vecs[3] = '{32'h00000000, 8'h80, 1, 32'hC0C0C0C0, 32'h40C0C0C0};
    for (int k = 0; k < 3; k++) begin
      pn[k] = 0; starve[k] = 0; done_m[k] = 1'b0; pw[k][0] = '0; pw[k][1] = '0;
    end

    // Reset forces outputs low even with both requesters active.
    rst_n = 1'b0; cpu_we = 1'b1; cpu_A = 1'b1; cpu_be = 4'hF; cpu_D = 32'hDEADBEEF;
    hex_valid = 1'b1; hex_value = 32'h12345678; hex_dp = 8'h00;
    #1;
    @(negedge clk);
    chk("rst_seg_we", 32'(seg_we), 32'd0);
    chk("rst_hex_ready", 32'(hex_ready), 32'd0);
    chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    tick();
    idle(1);
    rst_n = 1'b1; cpu_we = 1'b0; hex_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(hex_ready), 32'h7);
    tick();

    // Idle pass-through.
    cpu_we = 1'b1; cpu_A = 1'b1; cpu_be = 4'b0011; cpu_D = 32'h00001234;
    @(negedge clk);
    chk("pass_we", 32'(seg_we[0]), 32'd1);
    chk("pass_addr_be", {27'd0, seg_A[0], seg_be[0]}, 32'h13);
    chk("pass_data", seg_D[0], 32'h00001234);
    chk("pass_stall", 32'(cpu_stall[0]), 32'd0);
    tick();
    cpu_we = 1'b0;

    // Uncontended encodings.
    for (int v = 0; v < 4; v++) begin
      hex_valid = 1'b1; hex_value = vecs[v].val; hex_dp = vecs[v].dp;
      @(negedge clk);
      chk($sformatf("vec%0d_accept", v), 32'(hex_ready[vecs[v].k]), 32'd1);
      tick();
      hex_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_w0_we", v), {31'd0, seg_we[vecs[v].k]} | {30'd0, seg_A[vecs[v].k], 1'b0}, 32'd1);
      chk($sformatf("vec%0d_w0", v), seg_D[vecs[v].k], vecs[v].w0);
      tick();
      @(negedge clk);
      chk($sformatf("vec%0d_w1_addr", v), 32'(seg_A[vecs[v].k]), 32'd1);
      chk($sformatf("vec%0d_w1", v), seg_D[vecs[v].k], vecs[v].w1);
      tick();
      @(negedge clk);
      chk($sformatf("vec%0d_done", v), {30'd0, hex_done[vecs[v].k], hex_ready[vecs[v].k]}, 32'd3);
      tick();
    end

    // Contention: CPU writes in the three cycles after acceptance.
    hex_valid = 1'b1; hex_value = 32'h0123ABCD; hex_dp = 8'h00;
    idle(1);
    hex_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cpu_we = 1'b1; cpu_A = j[0]; cpu_be = 4'hF; cpu_D = 32'hC0DE0000 + j;
      @(negedge clk);
      chk($sformatf("cont_cpu%0d_data", j), seg_D[0], 32'hC0DE0000 + j);
      chk($sformatf("cont_cpu%0d_stall", j), 32'(cpu_stall[0]), 32'd0);
      tick();
    end
    cpu_we = 1'b0;
    @(negedge clk);
    chk("cont_w0", {seg_D[0][30:0], seg_A[0]}, {31'h4F5B063F, 1'b0});
    tick();
    @(negedge clk);
    chk("cont_w1", {seg_D[0][30:0], seg_A[0]}, {31'h5E397C77, 1'b1});
    tick();
    idle(4);

    // Starvation on the MAX_STALL=2 instance.
    cpu_we = 1'b1; cpu_A = 1'b0; cpu_be = 4'h1; cpu_D = 32'hA5A5A5A5;
    hex_valid = 1'b1;
    idle(1);
    hex_valid = 1'b0;
    idle(2);
    @(negedge clk);
    chk("starve_w0", {seg_D[2][29:0], cpu_stall[2], seg_A[2]}, {30'h0F5B063F, 1'b1, 1'b0});
    tick();
    idle(2);
    @(negedge clk);
    chk("starve_w1", {seg_D[2][29:0], cpu_stall[2], seg_A[2]}, {30'h1E397C77, 1'b1, 1'b1});
    tick();
    @(negedge clk);
    chk("starve_done", 32'(hex_done[2]), 32'd1);
    tick();
    cpu_we = 1'b0;
    idle(12);

    // Reset while word 1 is pending.
    hex_valid = 1'b1; hex_value = 32'hFEDCBA98; hex_dp = 8'h5A;
    idle(1);
    hex_valid = 1'b0;
    idle(1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_we", 32'(seg_we), 32'd0);
    tick();
    idle(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(hex_ready), 32'h7);
    chk("midrst_we_after", 32'(seg_we), 32'd0);
    tick();
    @(negedge clk);
    chk("midrst_no_done", 32'(hex_done), 32'd0);
    tick();

    // Randomized traffic against the model.
    repeat (500) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      cpu_we    = ($urandom_range(0, 2) != 0);
      cpu_A     = 1'($urandom_range(0, 1));
      cpu_be    = 4'($urandom_range(0, 15));
      cpu_D     = $urandom;
      hex_valid = ($urandom_range(0, 3) == 0);
      hex_value = $urandom;
      hex_dp    = 8'($urandom_range(0, 255));
      idle(1);
    end
    rst_n = 1'b1; cpu_we = 1'b0; hex_valid = 1'b0;
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
